// File: rtl/fpu_addsub_param.sv
// Multi-cycle add/subtract for the custom {sign, exp, man} float format, truncating rounding,
// with valid/ready handshakes on both sides and ZERO/OVERFLOW/UNDERFLOW/INEXACT status.
module fpu_addsub_param #(
    parameter int unsigned EXP_W = 6,
    parameter int unsigned MAN_W = 25,
    localparam int unsigned W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic [3:0]   status_out
);

    // Significand layout: {carry, hidden, man[MAN_W-1:0], guard, sticky}
    localparam int unsigned SW    = MAN_W + 4;
    localparam int unsigned MAXSH = MAN_W + 3;

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_e;

    state_e         state_q;
    logic           in_ready_q, out_valid_q;
    logic [W-1:0]   data_q;
    logic [3:0]     status_q;
    logic [W-1:0]   a_q, b_q;
    logic           rsvd_q, sign_q, sign_s_q, zero_q, uflow_q;
    logic [EXP_W:0] exp_q;
    logic [SW-1:0]  sig_l_q, sig_s_q, sum_q;

    logic [EXP_W-1:0] ea, eb, e_l, e_s, d;
    logic [MAN_W-1:0] ma, mb;
    logic             za, zb, swap, lost;
    logic [SW-1:0]    sig_a, sig_b, sig_s_pre, sig_s_al;
    int unsigned      sh;

    always_comb begin
        ea        = a_q[W-2 -: EXP_W];
        eb        = b_q[W-2 -: EXP_W];
        ma        = a_q[MAN_W-1:0];
        mb        = b_q[MAN_W-1:0];
        za        = (ea == '0);
        zb        = (eb == '0);
        // Flushed zeros always lose the magnitude compare.
        swap      = !zb && (za || ({eb, mb} > {ea, ma}));
        sig_a     = za ? '0 : {2'b01, ma, 2'b00};
        sig_b     = zb ? '0 : {2'b01, mb, 2'b00};
        e_l       = swap ? eb : ea;
        e_s       = swap ? ea : eb;
        d         = e_l - e_s;
        sh        = (32'(d) > MAXSH) ? MAXSH : 32'(d);
        sig_s_pre = swap ? sig_a : sig_b;
        lost      = |(sig_s_pre & ~({SW{1'b1}} << sh));
        sig_s_al  = (sig_s_pre >> sh) | {{(SW-1){1'b0}}, lost};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            status_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsvd_q      <= 1'b0;
            sign_q      <= 1'b0;
            sign_s_q    <= 1'b0;
            zero_q      <= 1'b0;
            uflow_q     <= 1'b0;
            exp_q       <= '0;
            sig_l_q     <= '0;
            sig_s_q     <= '0;
            sum_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= {b[W-1] ^ (op == 2'b01), b[W-2:0]};
                        rsvd_q     <= op[1];
                        zero_q     <= 1'b0;
                        uflow_q    <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= StAlign;
                    end
                end
                StAlign: begin
                    sign_q   <= swap ? b_q[W-1] : a_q[W-1];
                    sign_s_q <= swap ? a_q[W-1] : b_q[W-1];
                    exp_q    <= {1'b0, e_l};
                    sig_l_q  <= swap ? sig_b : sig_a;
                    sig_s_q  <= sig_s_al;
                    state_q  <= StAdd;
                end
                StAdd: begin
                    sum_q   <= (sign_q == sign_s_q) ? sig_l_q + sig_s_q : sig_l_q - sig_s_q;
                    state_q <= StNorm;
                end
                StNorm: begin
                    if (rsvd_q) begin
                        state_q <= StRound;
                    end else if (sum_q == '0) begin
                        zero_q  <= 1'b1;
                        state_q <= StRound;
                    end else if (sum_q[SW-1]) begin
                        sum_q   <= {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
                        exp_q   <= exp_q + 1'b1;
                        state_q <= StRound;
                    end else if (sum_q[SW-2]) begin
                        state_q <= StRound;
                    end else if (exp_q[EXP_W:1] == '0) begin
                        // A further left shift would take the exponent below 1.
                        uflow_q <= 1'b1;
                        state_q <= StRound;
                    end else begin
                        sum_q <= sum_q << 1;
                        exp_q <= exp_q - 1'b1;
                    end
                end
                StRound: begin
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                    if (rsvd_q) begin
                        data_q   <= a_q;
                        status_q <= {3'b000, a_q[W-2 -: EXP_W] == '0};
                    end else if (uflow_q) begin
                        data_q   <= '0;
                        status_q <= 4'b1101;
                    end else if (zero_q) begin
                        data_q   <= '0;
                        status_q <= 4'b0001;
                    end else if (exp_q[EXP_W]) begin
                        data_q   <= {sign_q, {(W-1){1'b1}}};
                        status_q <= 4'b1010;
                    end else begin
                        data_q   <= {sign_q, exp_q[EXP_W-1:0], sum_q[MAN_W+1:2]};
                        status_q <= {sum_q[1] | sum_q[0], 3'b000};
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign data_out   = data_q;
    assign status_out = status_q;

endmodule
